reservation_station_v2: RTL and testbench
=========================================

Name: reservation_station_v2

Overview:
- Parametrised, age-ordered, out-of-order issue queue between rename/dispatch and one execution unit.
- Holds up to QUEUE_SIZE micro-ops and wakes operands from RESULT_BUS_COUNT result buses, including same-cycle capture at enqueue.
- Issues the oldest ready op by wrap-around tag comparison.
- Adds over the previous generation: downstream back-pressure, result-bus valid qualifiers, free-slot count, and invalidation of the output register.

Parameters:
QUEUE_SIZE, 4, number of entries (>=2, any integer)
RESULT_BUS_COUNT, 2, number of result/wakeup buses
DATA_W, 32, operand and immediate width
TAG_W, 6, physical tag width; tags compared modulo 2^TAG_W

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-low (0 = reset)
IN_valid  in  1  dispatch offers an op this cycle
IN_opcode  in  6  opcode
IN_tagDst  in  TAG_W  destination tag; also the age key
IN_nmDst  in  5  architectural destination register
IN_imm  in  DATA_W  immediate
IN_tagA / IN_tagB  in  TAG_W  source tags
IN_availA / IN_availB  in  1  source value already present
IN_srcA / IN_srcB  in  DATA_W  source values (meaningful only when avail)
IN_resultValid  in  [RESULT_BUS_COUNT]  per-bus valid
IN_resultTag  in  [RESULT_BUS_COUNT] x TAG_W  per-bus tag
IN_resultBus  in  [RESULT_BUS_COUNT] x DATA_W  per-bus data
IN_invalidate  in  1  flush ops younger than IN_invalidateTag
IN_invalidateTag  in  TAG_W  flush boundary tag (itself survives)
IN_stall  in  1  execution unit cannot accept; hold output
OUT_valid  out  1  output op valid
OUT_operands  out  [3] x DATA_W  {srcA, srcB, imm}
OUT_opcode  out  6
OUT_tagDst  out  TAG_W
OUT_nmDst  out  5
OUT_full  out  1  no free entry (registered-state based)
OUT_freeCount  out  clog2(QUEUE_SIZE+1)  number of free entries

Behaviour:
- Reset (rst==0 at posedge):
  - All entry valid bits = 0.
  - OUT_valid = 0, OUT_full = 0, OUT_freeCount = QUEUE_SIZE.
  - All other outputs = 0.
  - Reset mid-operation discards everything, including a stalled output.
- OUT_full and OUT_freeCount are combinational from the current entry valid bits only.
- Enqueue:
  - IN_valid && !OUT_full writes the op to the lowest-index free entry at the posedge.
  - IN_valid while full is a protocol violation; the op is dropped and the bench asserts on it.
  - A slot freed by dequeue in cycle N is enqueueable from N+1, not N.
- Enqueue bypass: if IN_availX==0 and any bus i has IN_resultValid[i] && IN_resultTag[i]==IN_tagX, the entry stores availX=1 with that bus's data.
- Wakeup: each stored entry with availX==0 that matches a valid bus captures the data and sets availX=1 at the posedge.
  - If several buses match, the lowest bus index wins.
  - Buses with IN_resultValid=0 are ignored regardless of tag.
- Select: candidates are entries that are valid with availA && availB in the registered state.
  - The oldest wins: entry i beats entry j iff signed(tagDst_i - tagDst_j) < 0 (TAG_W-bit subtraction).
  - Ties (equal tags, illegal) go to the lower index.
- Output register:
  - Loads when a candidate exists and (!OUT_valid || !IN_stall). The winner's valid bit clears at the same edge and OUT_valid=1.
  - If no candidate exists and (!OUT_valid || !IN_stall), OUT_valid=0.
  - If OUT_valid && IN_stall, all outputs hold and nothing dequeues.
- Latency:
  - Op enqueued ready at edge E issues with OUT_valid at edge E+1 when it is the oldest candidate and the output is not stalled.
  - An op woken at edge W can issue at W+1.
- Invalidate (IN_invalidate==1): highest priority after reset.
  - Entries with signed(tagDst - IN_invalidateTag) > 0 are cleared.
  - If OUT_valid and OUT_tagDst is younger by the same rule, OUT_valid=0.
  - That cycle there is no enqueue (IN_valid ignored), no dequeue and no wakeup capture. Surviving entries and a surviving output are otherwise unchanged.
- Tag wrap-around: age ordering is correct while live tags span < 2^(TAG_W-1).

Test Plan:
- Reset, then 4 ops with tags 10,11,12,13, all operands available, IN_stall=0 -> OUT_tagDst 10,11,12,13 on consecutive cycles; OUT_freeCount returns to 4.
- Fill 4 entries with availA=0, tagA=20; one cycle later bus1 valid with tag 20, data 0xDEAD; bus0 valid with tag 21 -> all four capture srcA=0xDEAD, issue oldest-first from the next edge; an unqualified bus (valid=0) with tag 20 captures nothing.
- Enqueue an op with tagA=5 unavailable while bus0 carries tag 5, data 7 in the same cycle -> the op issues next edge with OUT_operands[0]=7.
- Tags 62,63,0,1 (TAG_W=6), all ready, enqueued in order 1,0,63,62 -> issue order 62,63,0,1.
- OUT_valid=1 with IN_stall=1 for 3 cycles, plus a ready older entry enqueued meanwhile -> outputs bit-stable for 3 cycles; the older op issues on the first unstalled edge.
- Entries with tags 3,4,5, output holds tag 6; invalidate with tag 4 while IN_valid=1 -> entries 3 and 4 survive, entry 5 is cleared, OUT_valid=0, the incoming op is dropped, OUT_freeCount=2.

Source files
------------

// File: rtl/reservation_station_v2.sv
// Age-ordered issue queue in front of one execution unit. Operands wake from
// qualified result buses, and the oldest ready op moves into a stallable output register.
module reservation_station_v2 #(
  parameter int QUEUE_SIZE       = 4,
  parameter int RESULT_BUS_COUNT = 2,
  parameter int DATA_W           = 32,
  parameter int TAG_W            = 6,
  localparam int CNT_W           = $clog2(QUEUE_SIZE + 1),
  localparam int IDX_W           = (QUEUE_SIZE > 1) ? $clog2(QUEUE_SIZE) : 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    IN_valid,
  input  logic [5:0]                              IN_opcode,
  input  logic [TAG_W-1:0]                        IN_tagDst,
  input  logic [4:0]                              IN_nmDst,
  input  logic [DATA_W-1:0]                       IN_imm,
  input  logic [TAG_W-1:0]                        IN_tagA,
  input  logic [TAG_W-1:0]                        IN_tagB,
  input  logic                                    IN_availA,
  input  logic                                    IN_availB,
  input  logic [DATA_W-1:0]                       IN_srcA,
  input  logic [DATA_W-1:0]                       IN_srcB,
  input  logic [RESULT_BUS_COUNT-1:0]             IN_resultValid,
  input  logic [RESULT_BUS_COUNT-1:0][TAG_W-1:0]  IN_resultTag,
  input  logic [RESULT_BUS_COUNT-1:0][DATA_W-1:0] IN_resultBus,
  input  logic                                    IN_invalidate,
  input  logic [TAG_W-1:0]                        IN_invalidateTag,
  input  logic                                    IN_stall,
  output logic                                    OUT_valid,
  output logic [2:0][DATA_W-1:0]                  OUT_operands,
  output logic [5:0]                              OUT_opcode,
  output logic [TAG_W-1:0]                        OUT_tagDst,
  output logic [4:0]                              OUT_nmDst,
  output logic                                    OUT_full,
  output logic [CNT_W-1:0]                        OUT_freeCount
);

  typedef struct packed {
    logic [5:0]        opcode;
    logic [TAG_W-1:0]  tag_dst;
    logic [4:0]        nm_dst;
    logic [DATA_W-1:0] imm;
    logic [TAG_W-1:0]  tag_a;
    logic [TAG_W-1:0]  tag_b;
    logic              avail_a;
    logic              avail_b;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
  } entry_t;

  logic [QUEUE_SIZE-1:0] valid_q, valid_d;
  entry_t                entries_q [QUEUE_SIZE];
  entry_t                entries_d [QUEUE_SIZE];

  logic                  out_valid_q, out_valid_d;
  logic [5:0]            out_opcode_q, out_opcode_d;
  logic [TAG_W-1:0]      out_tag_q, out_tag_d;
  logic [4:0]            out_nm_q, out_nm_d;
  logic [2:0][DATA_W-1:0] out_ops_q, out_ops_d;

  logic [CNT_W-1:0]      free_cnt;
  logic [IDX_W-1:0]      enq_idx;
  logic                  sel_found;
  logic [IDX_W-1:0]      sel_idx;

  logic                  byp_a, byp_b;
  logic [DATA_W-1:0]     byp_a_data, byp_b_data;
  logic                  wk_a [QUEUE_SIZE];
  logic                  wk_b [QUEUE_SIZE];
  logic [DATA_W-1:0]     wk_a_data [QUEUE_SIZE];
  logic [DATA_W-1:0]     wk_b_data [QUEUE_SIZE];

  // Age compare on the wrapped tag difference.
  function automatic logic is_older(input logic [TAG_W-1:0] a, input logic [TAG_W-1:0] b);
    logic [TAG_W-1:0] diff;
    diff = a - b;
    return diff[TAG_W-1];
  endfunction

  function automatic logic is_younger(input logic [TAG_W-1:0] a, input logic [TAG_W-1:0] b);
    logic [TAG_W-1:0] diff;
    diff = a - b;
    return !diff[TAG_W-1] && (diff != '0);
  endfunction

  always_comb begin
    free_cnt = '0;
    enq_idx  = '0;
    for (int i = QUEUE_SIZE - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_cnt = free_cnt + CNT_W'(1);
        enq_idx  = IDX_W'(i);
      end
    end
  end

  assign OUT_freeCount = free_cnt;
  assign OUT_full      = (free_cnt == '0);

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < QUEUE_SIZE; i++) begin
      if (valid_q[i] && entries_q[i].avail_a && entries_q[i].avail_b &&
          (!sel_found || is_older(entries_q[i].tag_dst, entries_q[sel_idx].tag_dst))) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  // Scanning buses from the top down leaves the lowest matching bus as the winner.
  always_comb begin
    byp_a      = 1'b0;
    byp_b      = 1'b0;
    byp_a_data = '0;
    byp_b_data = '0;
    for (int q = 0; q < QUEUE_SIZE; q++) begin
      wk_a[q]      = 1'b0;
      wk_b[q]      = 1'b0;
      wk_a_data[q] = '0;
      wk_b_data[q] = '0;
    end
    for (int b = RESULT_BUS_COUNT - 1; b >= 0; b--) begin
      if (IN_resultValid[b]) begin
        if (IN_resultTag[b] == IN_tagA) begin
          byp_a      = 1'b1;
          byp_a_data = IN_resultBus[b];
        end
        if (IN_resultTag[b] == IN_tagB) begin
          byp_b      = 1'b1;
          byp_b_data = IN_resultBus[b];
        end
        for (int q = 0; q < QUEUE_SIZE; q++) begin
          if (IN_resultTag[b] == entries_q[q].tag_a) begin
            wk_a[q]      = 1'b1;
            wk_a_data[q] = IN_resultBus[b];
          end
          if (IN_resultTag[b] == entries_q[q].tag_b) begin
            wk_b[q]      = 1'b1;
            wk_b_data[q] = IN_resultBus[b];
          end
        end
      end
    end
  end

  always_comb begin
    valid_d      = valid_q;
    entries_d    = entries_q;
    out_valid_d  = out_valid_q;
    out_opcode_d = out_opcode_q;
    out_tag_d    = out_tag_q;
    out_nm_d     = out_nm_q;
    out_ops_d    = out_ops_q;
    if (IN_invalidate) begin
      // A flush cycle freezes everything except the removal of younger ops.
      for (int i = 0; i < QUEUE_SIZE; i++) begin
        if (is_younger(entries_q[i].tag_dst, IN_invalidateTag)) valid_d[i] = 1'b0;
      end
      if (out_valid_q && is_younger(out_tag_q, IN_invalidateTag)) out_valid_d = 1'b0;
    end else begin
      if (!out_valid_q || !IN_stall) begin
        out_valid_d = sel_found;
        if (sel_found) begin
          out_opcode_d     = entries_q[sel_idx].opcode;
          out_tag_d        = entries_q[sel_idx].tag_dst;
          out_nm_d         = entries_q[sel_idx].nm_dst;
          out_ops_d[0]     = entries_q[sel_idx].src_a;
          out_ops_d[1]     = entries_q[sel_idx].src_b;
          out_ops_d[2]     = entries_q[sel_idx].imm;
          valid_d[sel_idx] = 1'b0;
        end
      end
      for (int i = 0; i < QUEUE_SIZE; i++) begin
        if (!entries_q[i].avail_a && wk_a[i]) begin
          entries_d[i].avail_a = 1'b1;
          entries_d[i].src_a   = wk_a_data[i];
        end
        if (!entries_q[i].avail_b && wk_b[i]) begin
          entries_d[i].avail_b = 1'b1;
          entries_d[i].src_b   = wk_b_data[i];
        end
      end
      if (IN_valid && !OUT_full) begin
        valid_d[enq_idx]           = 1'b1;
        entries_d[enq_idx].opcode  = IN_opcode;
        entries_d[enq_idx].tag_dst = IN_tagDst;
        entries_d[enq_idx].nm_dst  = IN_nmDst;
        entries_d[enq_idx].imm     = IN_imm;
        entries_d[enq_idx].tag_a   = IN_tagA;
        entries_d[enq_idx].tag_b   = IN_tagB;
        entries_d[enq_idx].avail_a = IN_availA || byp_a;
        entries_d[enq_idx].avail_b = IN_availB || byp_b;
        entries_d[enq_idx].src_a   = IN_availA ? IN_srcA : byp_a_data;
        entries_d[enq_idx].src_b   = IN_availB ? IN_srcB : byp_b_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q      <= '0;
      out_valid_q  <= 1'b0;
      out_opcode_q <= '0;
      out_tag_q    <= '0;
      out_nm_q     <= '0;
      out_ops_q    <= '0;
      for (int i = 0; i < QUEUE_SIZE; i++) entries_q[i] <= '0;
    end else begin
      valid_q      <= valid_d;
      out_valid_q  <= out_valid_d;
      out_opcode_q <= out_opcode_d;
      out_tag_q    <= out_tag_d;
      out_nm_q     <= out_nm_d;
      out_ops_q    <= out_ops_d;
      for (int i = 0; i < QUEUE_SIZE; i++) entries_q[i] <= entries_d[i];
    end
  end

  assign OUT_valid    = out_valid_q;
  assign OUT_opcode   = out_opcode_q;
  assign OUT_tagDst   = out_tag_q;
  assign OUT_nmDst    = out_nm_q;
  assign OUT_operands = out_ops_q;

endmodule

// File: tb/tb_reservation_station_v2.sv
// Directed scenarios plus randomized traffic against a queue-based model of
// the issue rules (oldest ready op first, bus wakeup, flush, stall).
module tb_reservation_station_v2;
  localparam int Q = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              IN_valid;
  logic [5:0]        IN_opcode;
  logic [5:0]        IN_tagDst;
  logic [4:0]        IN_nmDst;
  logic [31:0]       IN_imm;
  logic [5:0]        IN_tagA, IN_tagB;
  logic              IN_availA, IN_availB;
  logic [31:0]       IN_srcA, IN_srcB;
  logic [1:0]        IN_resultValid;
  logic [1:0][5:0]   IN_resultTag;
  logic [1:0][31:0]  IN_resultBus;
  logic              IN_invalidate;
  logic [5:0]        IN_invalidateTag;
  logic              IN_stall;
  logic              OUT_valid;
  logic [2:0][31:0]  OUT_operands;
  logic [5:0]        OUT_opcode;
  logic [5:0]        OUT_tagDst;
  logic [4:0]        OUT_nmDst;
  logic              OUT_full;
  logic [2:0]        OUT_freeCount;

  reservation_station_v2 #(.QUEUE_SIZE(Q), .RESULT_BUS_COUNT(2), .DATA_W(32), .TAG_W(6)) dut (
    .clk(clk), .rst(rst), .IN_valid(IN_valid), .IN_opcode(IN_opcode), .IN_tagDst(IN_tagDst),
    .IN_nmDst(IN_nmDst), .IN_imm(IN_imm), .IN_tagA(IN_tagA), .IN_tagB(IN_tagB),
    .IN_availA(IN_availA), .IN_availB(IN_availB), .IN_srcA(IN_srcA), .IN_srcB(IN_srcB),
    .IN_resultValid(IN_resultValid), .IN_resultTag(IN_resultTag), .IN_resultBus(IN_resultBus),
    .IN_invalidate(IN_invalidate), .IN_invalidateTag(IN_invalidateTag), .IN_stall(IN_stall),
    .OUT_valid(OUT_valid), .OUT_operands(OUT_operands), .OUT_opcode(OUT_opcode),
    .OUT_tagDst(OUT_tagDst), .OUT_nmDst(OUT_nmDst), .OUT_full(OUT_full),
    .OUT_freeCount(OUT_freeCount)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [5:0]  tag;
    logic [4:0]  nm;
    logic [31:0] imm;
    logic [5:0]  ta, tb;
    logic        aa, ab;
    logic [31:0] sa, sb;
  } m_op_t;

  m_op_t mq[$];
  m_op_t m_out;
  logic  m_out_valid;
  logic  m_loaded;
  logic  record;
  int    issued_tag[$];
  int    issued_sa[$];
  int    n_vec = 0;
  int    n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic is_older(input logic [5:0] a, input logic [5:0] b);
    logic signed [5:0] d;
    d = a - b;
    return d < 0;
  endfunction

  function automatic logic is_younger(input logic [5:0] a, input logic [5:0] b);
    logic signed [5:0] d;
    d = a - b;
    return d > 0;
  endfunction

  task automatic bus_lookup(input logic [5:0] tag, output logic hit, output logic [31:0] data);
    hit = 1'b0;
    data = '0;
    for (int b = 0; b < 2; b++) begin
      if (!hit && IN_resultValid[b] && IN_resultTag[b] == tag) begin
        hit = 1'b1;
        data = IN_resultBus[b];
      end
    end
  endtask

  // Reference behaviour at one rising edge, computed from the queue contents.
  task automatic model_edge();
    int pre_size;
    int win;
    logic hit;
    logic [31:0] data;
    m_op_t n;
    m_loaded = 1'b0;
    if (!rst) begin
      mq.delete();
      m_out_valid = 1'b0;
      m_out = '0;
      return;
    end
    if (IN_invalidate) begin
      for (int i = mq.size() - 1; i >= 0; i--)
        if (is_younger(mq[i].tag, IN_invalidateTag)) mq.delete(i);
      if (m_out_valid && is_younger(m_out.tag, IN_invalidateTag)) m_out_valid = 1'b0;
      return;
    end
    pre_size = mq.size();
    if (!m_out_valid || !IN_stall) begin
      win = -1;
      foreach (mq[i]) begin
        if (mq[i].aa && mq[i].ab) begin
          logic beaten;
          beaten = 1'b0;
          foreach (mq[j]) if (j != i && mq[j].aa && mq[j].ab && is_older(mq[j].tag, mq[i].tag)) beaten = 1'b1;
          if (!beaten) win = i;
        end
      end
      if (win >= 0) begin
        m_out = mq[win];
        m_out_valid = 1'b1;
        m_loaded = 1'b1;
        mq.delete(win);
      end else begin
        m_out_valid = 1'b0;
      end
    end
    foreach (mq[i]) begin
      if (!mq[i].aa) begin
        bus_lookup(mq[i].ta, hit, data);
        if (hit) begin mq[i].aa = 1'b1; mq[i].sa = data; end
      end
      if (!mq[i].ab) begin
        bus_lookup(mq[i].tb, hit, data);
        if (hit) begin mq[i].ab = 1'b1; mq[i].sb = data; end
      end
    end
    if (IN_valid && pre_size < Q) begin
      n.opcode = IN_opcode; n.tag = IN_tagDst; n.nm = IN_nmDst; n.imm = IN_imm;
      n.ta = IN_tagA; n.tb = IN_tagB; n.aa = IN_availA; n.ab = IN_availB;
      n.sa = IN_srcA; n.sb = IN_srcB;
      if (!n.aa) begin bus_lookup(n.ta, hit, data); if (hit) begin n.aa = 1'b1; n.sa = data; end end
      if (!n.ab) begin bus_lookup(n.tb, hit, data); if (hit) begin n.ab = 1'b1; n.sb = data; end end
      mq.push_back(n);
    end
  endtask

  task automatic compare_all();
    check_val("out_valid", OUT_valid, m_out_valid);
    check_val("free_count", OUT_freeCount, Q - mq.size());
    check_val("full", OUT_full, mq.size() == Q);
    if (m_out_valid) begin
      check_val("out_tag", OUT_tagDst, m_out.tag);
      check_val("out_opcode", OUT_opcode, m_out.opcode);
      check_val("out_nm", OUT_nmDst, m_out.nm);
      check_val("out_srcA", OUT_operands[0], m_out.sa);
      check_val("out_srcB", OUT_operands[1], m_out.sb);
      check_val("out_imm", OUT_operands[2], m_out.imm);
    end
    if (m_loaded) begin
      $display("issue tag=%0d opcode=%0h srcA=%h srcB=%h imm=%h",
               OUT_tagDst, OUT_opcode, OUT_operands[0], OUT_operands[1], OUT_operands[2]);
      if (record) begin
        issued_tag.push_back(int'(OUT_tagDst));
        issued_sa.push_back(int'(OUT_operands[0]));
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle();
    rst = 1'b1;
    IN_valid = 1'b0;
    IN_resultValid = '0;
    IN_invalidate = 1'b0;
    IN_stall = 1'b0;
  endtask

  task automatic set_op(input logic [5:0] tag, input logic aa, input logic [5:0] ta,
                        input logic [31:0] sa, input logic ab, input logic [5:0] tb,
                        input logic [31:0] sb);
    IN_valid = 1'b1;
    IN_tagDst = tag;
    IN_opcode = tag ^ 6'h2a;
    IN_nmDst = tag[4:0];
    IN_imm = $urandom;
    IN_availA = aa; IN_tagA = ta; IN_srcA = sa;
    IN_availB = ab; IN_tagB = tb; IN_srcB = sb;
  endtask

  task automatic pop_issue(input string name, input int exp_tag);
    if (issued_tag.size() == 0) begin
      check_val(name, 64'hffff, exp_tag);
    end else begin
      check_val(name, issued_tag.pop_front(), exp_tag);
      void'(issued_sa.pop_front());
    end
  endtask

  task automatic begin_test();
    idle();
    for (int i = 0; i < 4; i++) step();
    issued_tag.delete();
    issued_sa.delete();
    record = 1'b1;
  endtask

  function automatic logic [5:0] pick_pending();
    int best;
    best = -1;
    foreach (mq[i])
      if (!(mq[i].aa && mq[i].ab) && (best < 0 || is_older(mq[i].tag, mq[best].tag))) best = i;
    if (best < 0) return 6'($urandom_range(0, 63));
    return mq[best].aa ? mq[best].tb : mq[best].ta;
  endfunction

  initial begin
    logic [5:0] next_tag;
    record = 1'b0;
    m_out = '0;
    m_out_valid = 1'b0;
    m_loaded = 1'b0;
    idle();
    IN_opcode = '0; IN_tagDst = '0; IN_nmDst = '0; IN_imm = '0;
    IN_tagA = '0; IN_tagB = '0; IN_availA = 1'b0; IN_availB = 1'b0;
    IN_srcA = '0; IN_srcB = '0; IN_resultTag = '0; IN_resultBus = '0; IN_invalidateTag = '0;
    rst = 1'b0;
    step();
    step();
    check_val("rst_valid", OUT_valid, 1'b0);
    check_val("rst_full", OUT_full, 1'b0);
    check_val("rst_free", OUT_freeCount, 3'd4);
    check_val("rst_tag", OUT_tagDst, 6'd0);
    check_val("rst_ops", OUT_operands, 96'd0);
    check_val("rst_opcode_nm", {OUT_opcode, OUT_nmDst}, 11'd0);

    // In-order ready ops issue back to back.
    begin_test();
    for (int t = 10; t < 14; t++) begin set_op(6'(t), 1, 0, $urandom, 1, 0, $urandom); step(); end
    idle();
    for (int i = 0; i < 3; i++) step();
    for (int t = 10; t < 14; t++) pop_issue("seq_order", t);
    check_val("seq_free", OUT_freeCount, 3'd4);

    // Bus wakeup with an unqualified bus first.
    begin_test();
    for (int t = 30; t < 34; t++) begin set_op(6'(t), 0, 20, 0, 1, 0, $urandom); step(); end
    idle();
    IN_resultValid = 2'b00; IN_resultTag[0] = 20; IN_resultBus[0] = 32'h1111;
    step();
    check_val("unqual_valid", OUT_valid, 1'b0);
    check_val("unqual_free", OUT_freeCount, 3'd0);
    IN_resultValid = 2'b11; IN_resultTag[0] = 21; IN_resultBus[0] = 32'hbeef;
    IN_resultTag[1] = 20; IN_resultBus[1] = 32'hdead;
    step();
    idle();
    for (int i = 0; i < 5; i++) step();
    for (int t = 30; t < 34; t++) begin
      check_val("wake_srcA", (issued_sa.size() > 0) ? issued_sa[0] : -1, 32'hdead);
      pop_issue("wake_order", t);
    end

    // Same-cycle capture at enqueue.
    begin_test();
    set_op(40, 0, 5, 0, 1, 0, 32'h55);
    IN_resultValid = 2'b01; IN_resultTag[0] = 5; IN_resultBus[0] = 32'd7;
    step();
    idle();
    step();
    check_val("byp_valid", OUT_valid, 1'b1);
    check_val("byp_srcA", OUT_operands[0], 32'd7);

    // Wrap-around ordering behind a stalled blocker.
    begin_test();
    set_op(60, 1, 0, 1, 1, 0, 2); step();
    set_op(1, 1, 0, 3, 1, 0, 4); IN_stall = 1'b1; step();
    set_op(0, 1, 0, 5, 1, 0, 6); step();
    set_op(63, 1, 0, 7, 1, 0, 8); step();
    set_op(62, 1, 0, 9, 1, 0, 10); step();
    idle();
    for (int i = 0; i < 6; i++) step();
    pop_issue("wrap_order", 60);
    pop_issue("wrap_order", 62);
    pop_issue("wrap_order", 63);
    pop_issue("wrap_order", 0);
    pop_issue("wrap_order", 1);

    // Stall holds the output while an older op arrives.
    begin_test();
    set_op(50, 1, 0, 11, 1, 0, 12); step();
    set_op(52, 1, 0, 13, 1, 0, 14); IN_stall = 1'b1; step();
    set_op(51, 1, 0, 15, 1, 0, 16); step();
    check_val("stall_tag", OUT_tagDst, 6'd50);
    IN_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check_val("stall_hold", {OUT_valid, OUT_tagDst}, {1'b1, 6'd50});
    end
    idle();
    step();
    check_val("unstall_tag", OUT_tagDst, 6'd51);
    step();
    check_val("unstall_next", OUT_tagDst, 6'd52);

    // Flush younger than tag 4 while dispatch offers an op.
    begin_test();
    for (int t = 3; t < 6; t++) begin set_op(6'(t), 0, 44, 0, 1, 0, 1); step(); end
    set_op(6, 1, 0, 2, 1, 0, 3); step();
    idle(); IN_stall = 1'b1; step();
    check_val("pre_inv_tag", OUT_tagDst, 6'd6);
    set_op(7, 1, 0, 4, 1, 0, 5);
    IN_invalidate = 1'b1; IN_invalidateTag = 4; IN_stall = 1'b1;
    IN_resultValid = 2'b01; IN_resultTag[0] = 44; IN_resultBus[0] = 32'h44;
    step();
    check_val("inv_valid", OUT_valid, 1'b0);
    check_val("inv_free", OUT_freeCount, 3'd2);
    idle();
    IN_resultValid = 2'b01; IN_resultTag[0] = 44; IN_resultBus[0] = 32'h44;
    step();
    idle();
    for (int i = 0; i < 3; i++) step();
    pop_issue("inv_order", 6);
    pop_issue("inv_order", 3);
    pop_issue("inv_order", 4);
    check_val("inv_drain_free", OUT_freeCount, 3'd4);

    // Randomized traffic.
    record = 1'b0;
    next_tag = 8;
    for (int c = 0; c < 3000; c++) begin
      idle();
      rst = ($urandom_range(0, 199) != 0);
      IN_stall = ($urandom_range(0, 99) < 30);
      IN_invalidate = ($urandom_range(0, 99) < 3);
      IN_invalidateTag = (mq.size() > 0) ? mq[$urandom_range(0, mq.size() - 1)].tag : next_tag;
      if (($urandom_range(0, 99) < 60) && mq.size() < Q) begin
        set_op(next_tag, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), $urandom,
               1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), $urandom);
        next_tag = next_tag + 6'd1;
      end
      IN_resultValid = 2'($urandom_range(0, 3));
      IN_resultTag[0] = ($urandom_range(0, 1) != 0) ? pick_pending() : 6'($urandom_range(0, 63));
      IN_resultTag[1] = ($urandom_range(0, 2) == 0) ? IN_tagA : pick_pending();
      if ($urandom_range(0, 9) == 0) IN_resultTag[1] = IN_resultTag[0];
      IN_resultBus[0] = $urandom;
      IN_resultBus[1] = $urandom;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
